// File: rtl/mmio_pkg.sv
// Shared encodings and helpers for the MM/IO bridge.
package mmio_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MM_ACC  = 3'd1,
    S_MM_CAP  = 3'd2,
    S_IO_REQ  = 3'd3,
    S_IO_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Wide enough for any DATA_W in use; callers truncate with a size cast.
  localparam logic [255:0] ALL_ONES = '1;

  // Channel index width: clog2(n), never below one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// IO wait-cycle counter; only built when MMIO_BRIDGE_TIMEOUT_EN is defined.
module mmio_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired marks the TIMEOUT-th enabled cycle, so the wait ends on that cycle.
  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Datapath-to-memory/peripheral bridge with req/ack sequencing and busy stall.
// Optional IO wait timeout: define MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int IO_DATA_W   = 8,
  parameter int N_IO        = 4,
  parameter int IO_BASE_BIT = 12,
  parameter int TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      busy,
  output logic                      err,
  output logic                      mm_rd,
  output logic                      mm_wr,
  output logic [ADDR_W-1:0]         mm_addr,
  output logic [DATA_W-1:0]         mm_wdata,
  input  logic [DATA_W-1:0]         mm_rdata,
  output logic [N_IO-1:0]           io_sel,
  output logic                      io_rd,
  output logic                      io_wr,
  output logic [IO_DATA_W-1:0]      io_wdata,
  input  logic [N_IO*IO_DATA_W-1:0] io_rdata,
  input  logic [N_IO-1:0]           io_ack
);

  localparam int CH_W  = ch_w(N_IO);
  localparam int PAD_N = 1 << CH_W;
  localparam int PAD_W = PAD_N * IO_DATA_W;

  state_t            state, state_nx;
  logic              op_wr, op_wr_nx, req, accept, bad_ch, ack_hit, expired;
  logic [ADDR_W-1:0] addr_nx;
  logic [CH_W-1:0]   ch, ch_nx;
  logic [31:0]       ch_req;
  logic [PAD_N-1:0]  ack_pad;
  logic [PAD_W-1:0]  rdata_pad;

  // Pad per-channel inputs to a power of two so any ch index stays in range.
  assign ack_pad   = PAD_N'(io_ack);
  assign rdata_pad = PAD_W'(io_rdata);

  assign req     = rd | wr;
  assign accept  = (state == S_IDLE) && req;
  assign ch      = mm_addr[2 +: CH_W];
  assign ack_hit = ack_pad[ch];
  assign ch_req  = 32'(address[2 +: CH_W]);
  assign bad_ch  = address[IO_BASE_BIT] && (ch_req >= N_IO);
  assign addr_nx = accept ? address : mm_addr;
  assign ch_nx   = addr_nx[2 +: CH_W];
  assign op_wr_nx = (state == S_IDLE) ? wr : op_wr;

  assign busy = rst & (((state != S_IDLE) && (state != S_DONE)) || accept);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  mmio_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_IO_REQ),
    .enable  (state == S_IO_WAIT),
    .expired (expired)
  );
`else
  // No counter: with TIMEOUT >= 1 this is constant 0 and the wait never expires.
  assign expired = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req) begin
        if (!address[IO_BASE_BIT]) state_nx = S_MM_ACC;
        else if (!bad_ch)          state_nx = S_IO_REQ;
        else                       state_nx = S_DONE;
      end
      S_MM_ACC:  state_nx = S_MM_CAP;
      S_MM_CAP:  state_nx = S_DONE;
      S_IO_REQ:  state_nx = S_IO_WAIT;
      S_IO_WAIT: if (ack_hit || expired) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Strobes and select are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_wr <= 1'b0; err <= 1'b0; data_out <= '0;
      mm_rd <= 1'b0; mm_wr <= 1'b0; mm_addr <= '0; mm_wdata <= '0;
      io_sel <= '0; io_rd <= 1'b0; io_wr <= 1'b0; io_wdata <= '0;
    end else begin
      mm_rd  <= (state_nx == S_MM_ACC) && !op_wr_nx;
      mm_wr  <= (state_nx == S_MM_ACC) &&  op_wr_nx;
      io_rd  <= (state_nx == S_IO_REQ) && !op_wr_nx;
      io_wr  <= (state_nx == S_IO_REQ) &&  op_wr_nx;
      io_sel <= ((state_nx == S_IO_REQ) || (state_nx == S_IO_WAIT)) ? (N_IO'(1) << ch_nx) : '0;
      if (accept) begin
        mm_addr  <= address;
        mm_wdata <= data_in;
        io_wdata <= data_in[IO_DATA_W-1:0];
        op_wr    <= wr;
        if (rd && wr) err <= 1'b1;
        if (bad_ch) begin
          err      <= 1'b1;
          data_out <= DATA_W'(ALL_ONES);
        end
      end
      if (state == S_MM_CAP && !op_wr) data_out <= mm_rdata;
      if (state == S_IO_WAIT) begin
        if (ack_hit) begin
          if (!op_wr) data_out <= DATA_W'(rdata_pad[int'(ch)*IO_DATA_W +: IO_DATA_W]);
        end else if (expired) begin
          err <= 1'b1;
          if (!op_wr) data_out <= DATA_W'(ALL_ONES);
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge (N_IO=3 so an out-of-range channel exists).
module tb_mmio_bridge;

  localparam int N_IO = 3;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [31:0] address, data_in, data_out, mm_addr, mm_wdata, mm_rdata;
  logic        busy, err, mm_rd, mm_wr, io_rd, io_wr;
  logic [2:0]  io_sel, io_ack;
  logic [7:0]  io_wdata;
  logic [23:0] io_rdata;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] dout_exp;
  logic        err_exp;
  bit          prev_mmrd = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mmio_bridge #(.N_IO(N_IO), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .address(address), .data_in(data_in),
    .data_out(data_out), .busy(busy), .err(err),
    .mm_rd(mm_rd), .mm_wr(mm_wr), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One requester transaction; dly = IO_WAIT cycles before ack, <0 = never ack.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int dly, input logic [7:0] slot);
    int ch, exp_busy, busy_n, mmr, mmw, ior, iow, sel_n, waitc;
    logic io, bad, ok_io;
    logic [2:0] sel;
    bit req_seen, done;
    ch = int'(a[3:2]);
    io = a[12];
    bad = io && (ch >= N_IO);
    ok_io = io && !bad;
    sel = ok_io ? 3'(1 << ch) : 3'b000;
    if (!io)         exp_busy = 3;
    else if (bad)    exp_busy = 1;
    else if (dly < 0) exp_busy = 2 + TMO;
    else             exp_busy = 3 + dly;
    if ((r && w) || bad || (ok_io && dly < 0)) err_exp = 1'b1;
    if (bad) dout_exp = 32'hFFFF_FFFF;
    else if (!w) begin
      if (!io)          dout_exp = mem_rd(a);
      else if (dly < 0) dout_exp = 32'hFFFF_FFFF;
      else              dout_exp = {24'h0, slot};
    end
    busy_n = 0; mmr = 0; mmw = 0; ior = 0; iow = 0; sel_n = 0; waitc = -1;
    req_seen = 0; done = 0;
    @(negedge clk);
    rd = r; wr = w; address = a; data_in = d;
    #1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!busy) begin done = 1; break; end
      busy_n++;
      io_rdata = 24'($urandom);
      io_ack = 3'($urandom) & ~sel;
      if (waitc >= 0 && waitc == dly) begin
        io_ack = sel;
        io_rdata[ch*8 +: 8] = slot;
      end
      @(posedge clk); #1;
      mm_rdata = prev_mmrd ? mem_rd(mm_addr) : $urandom;
      prev_mmrd = mm_rd;
      if (mm_rd) begin mmr++; chk("mm_addr_rd", mm_addr, a); end
      if (mm_wr) begin
        mmw++;
        chk("mm_addr_wr", mm_addr, a);
        chk("mm_wdata", mm_wdata, d);
        mem[mm_addr] = mm_wdata;
      end
      if (req_seen) begin waitc = 0; req_seen = 0; end
      else if (waitc >= 0) waitc++;
      if (io_rd) ior++;
      if (io_wr) begin iow++; chk("io_wdata", io_wdata, d[7:0]); end
      if (io_rd || io_wr) req_seen = 1;
      if (io_sel != 3'b000) begin sel_n++; chk("io_sel", io_sel, sel); end
      @(negedge clk);
    end
    rd = 0; wr = 0; io_ack = 0;
    chk("completed", done, 1);
    chk("busy_cycles", busy_n, exp_busy);
    chk("data_out", data_out, dout_exp);
    chk("err", err, err_exp);
    chk("mm_rd_pulses", mmr, (!io && !w) ? 1 : 0);
    chk("mm_wr_pulses", mmw, (!io && w) ? 1 : 0);
    chk("io_rd_pulses", ior, (ok_io && !w) ? 1 : 0);
    chk("io_wr_pulses", iow, (ok_io && w) ? 1 : 0);
    chk("io_sel_cycles", sel_n, !ok_io ? 0 : (dly < 0 ? TMO + 1 : dly + 2));
  endtask

  initial begin
    logic [31:0] a;
    logic w;
    rst = 0; rd = 0; wr = 0; address = 0; data_in = 0;
    mm_rdata = 0; io_rdata = 0; io_ack = 0;
    dout_exp = 0; err_exp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {mm_rd, mm_wr, io_rd, io_wr}, 0);
    chk("rst_io_sel", io_sel, 0);
    chk("rst_latches", {mm_addr, mm_wdata, io_wdata}, 0);
    rst = 1;

    // Directed cases
    mem[32'h40] = 32'hDEAD_BEEF;
    access(1, 0, 32'h0000_0040, 32'h0, 0, 8'h00);
    chk("mm_read_value", data_out, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_1008, 32'h5A, 2, 8'h00);
    chk("io_write_keeps_dout", data_out, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_1004, 32'h0, 4, 8'hA5);
    chk("io_read_value", data_out, 32'h0000_00A5);

    // Randomized legal traffic
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) << 2;
      else a = 32'h1000 | (32'($urandom_range(0, N_IO - 1)) << 2) | ($urandom & 32'hFFFF_E000);
      access(!w, w, a, $urandom, $urandom_range(0, 5), 8'($urandom));
    end

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    access(1, 0, 32'h0000_1000, 32'h0, -1, 8'h00);
`endif

    // Channel index beyond N_IO
    access(1, 0, 32'h0000_100C, 32'h0, 0, 8'h00);

    // Reset while waiting on a peripheral
    @(negedge clk);
    rd = 1; wr = 0; address = 32'h0000_1004; io_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("io_sel_held_in_wait", io_sel, 3'b010);
    rst = 0; rd = 0;
    @(posedge clk); #1;
    chk("abort_io_sel", io_sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_data_out", data_out, 0);
    chk("abort_strobes", {io_rd, io_wr, mm_rd, mm_wr}, 0);
    @(negedge clk);
    rst = 1; err_exp = 0; dout_exp = 0; prev_mmrd = 0;

    // rd and wr together: treated as a write, flags error
    access(1, 1, 32'h0000_0080, 32'h1234_5678, 0, 8'h00);
    access(1, 0, 32'h0000_0080, 32'h0, 0, 8'h00);
    chk("rdwr_readback", data_out, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
